// File: rtl/io_xbar_input_port.sv
// Crossbar input port: credit-based flit FIFO with a header/body FSM that routes each packet to one of four outputs.
// Optional sticky overflow detection is built when IO_XBAR_INPUT_OVERFLOW_CHECK_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef CHIP_ID_WIDTH
`define CHIP_ID_WIDTH 14
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef PAYLOAD_LEN
`define PAYLOAD_LEN 8
`endif

module io_xbar_input_port #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic [`DATA_WIDTH-1:0] data_in,
  output logic                   yummy_out,
  input  logic                   thanks_0_in,
  input  logic                   thanks_1_in,
  input  logic                   thanks_2_in,
  input  logic                   thanks_3_in,
  output logic                   valid_out,
  output logic [`DATA_WIDTH-1:0] data_out,
  output logic                   route_req_0_out,
  output logic                   route_req_1_out,
  output logic                   route_req_2_out,
  output logic                   route_req_3_out,
  output logic                   tail_out,
  output logic                   overflow_err
);

  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;
  localparam int LEN_MSB   = `DATA_WIDTH - `CHIP_ID_WIDTH - 2*`XY_WIDTH - 4;
  localparam int ROUTE_LSB = `DATA_WIDTH - `CHIP_ID_WIDTH - `XY_WIDTH;

  // Valid/ready contract: a flit is accepted whenever valid_in is high and there is room
  // (or the head leaves in the same cycle); the head leaves when valid_out is high and the
  // thanks of the currently requested output is high. Credits are returned via yummy_out.

  typedef enum logic {HEADER = 1'b0, BODY = 1'b1} state_t;

  logic [`DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       count;
  state_t                 state;
  logic [1:0]             route_q;
  logic [`PAYLOAD_LEN-1:0] remaining;

  logic [`PAYLOAD_LEN-1:0] hdr_len;
  logic [1:0]              hdr_route;
  logic [1:0]              cur_route;
  logic                    thanks_sel;
  logic                    full, pop, push_ok;

  assign valid_out = (count != '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign data_out  = mem[rd_ptr];
  assign hdr_len   = data_out[LEN_MSB -: `PAYLOAD_LEN];
  assign hdr_route = data_out[ROUTE_LSB+1 : ROUTE_LSB];
  assign cur_route = (state == HEADER) ? hdr_route : route_q;

  always_comb begin
    thanks_sel = 1'b0;
    case (cur_route)
      2'd0: thanks_sel = thanks_0_in;
      2'd1: thanks_sel = thanks_1_in;
      2'd2: thanks_sel = thanks_2_in;
      2'd3: thanks_sel = thanks_3_in;
      default: thanks_sel = 1'b0;
    endcase
  end

  assign pop     = valid_out && thanks_sel;
  assign push_ok = valid_in && (!full || pop);

  assign route_req_0_out = valid_out && (cur_route == 2'd0);
  assign route_req_1_out = valid_out && (cur_route == 2'd1);
  assign route_req_2_out = valid_out && (cur_route == 2'd2);
  assign route_req_3_out = valid_out && (cur_route == 2'd3);
  assign tail_out = valid_out &&
                    (((state == HEADER) && (hdr_len == '0)) ||
                     ((state == BODY) && (remaining == `PAYLOAD_LEN'(1))));

  // Storage is not reset: contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      yummy_out <= 1'b0;
    end else begin
      yummy_out <= pop;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HEADER;
      route_q   <= 2'd0;
      remaining <= '0;
    end else if (pop) begin
      case (state)
        HEADER: begin
          if (hdr_len != '0) begin
            route_q   <= hdr_route;
            remaining <= hdr_len;
            state     <= BODY;
          end
        end
        BODY: begin
          remaining <= remaining - `PAYLOAD_LEN'(1);
          if (remaining == `PAYLOAD_LEN'(1)) state <= HEADER;
        end
        default: state <= HEADER;
      endcase
    end
  end

`ifdef IO_XBAR_INPUT_OVERFLOW_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      overflow_err <= 1'b0;
    else if (valid_in && full && !pop) overflow_err <= 1'b1;
  end
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_io_xbar_input_port.sv
// Directed bench for io_xbar_input_port (FIFO_DEPTH=4, 64-bit flits, length at [30:23], route at [43:42]).
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef CHIP_ID_WIDTH
`define CHIP_ID_WIDTH 14
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef PAYLOAD_LEN
`define PAYLOAD_LEN 8
`endif

module tb_io_xbar_input_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [63:0] data_in;
  logic        yummy_out;
  logic        thanks_0_in, thanks_1_in, thanks_2_in, thanks_3_in;
  logic        valid_out;
  logic [63:0] data_out;
  logic        route_req_0_out, route_req_1_out, route_req_2_out, route_req_3_out;
  logic        tail_out;
  logic        overflow_err;

  int checks   = 0;
  int failures = 0;

`ifdef IO_XBAR_INPUT_OVERFLOW_CHECK_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  io_xbar_input_port #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .yummy_out(yummy_out),
    .thanks_0_in(thanks_0_in), .thanks_1_in(thanks_1_in),
    .thanks_2_in(thanks_2_in), .thanks_3_in(thanks_3_in),
    .valid_out(valid_out), .data_out(data_out),
    .route_req_0_out(route_req_0_out), .route_req_1_out(route_req_1_out),
    .route_req_2_out(route_req_2_out), .route_req_3_out(route_req_3_out),
    .tail_out(tail_out), .overflow_err(overflow_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Header flit: length at [30:23], route (X low bits) at [43:42], tag in [15:0].
  function automatic logic [63:0] hdr(input logic [7:0] len, input logic [1:0] route,
                                      input logic [15:0] tag);
    logic [63:0] f;
    f = 64'h0;
    f[30:23] = len;
    f[43:42] = route;
    f[15:0]  = tag;
    return f;
  endfunction

  // Body flits carry route bits 3 and a non-zero length field so a wrong decode shows up.
  function automatic logic [63:0] body(input logic [15:0] tag);
    return {48'hFFFF_FFFF_FFFF, tag};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic exp_valid, input logic [3:0] exp_rr,
                         input logic exp_tail);
    chk({tag, "_valid"}, 64'(valid_out), 64'(exp_valid));
    chk({tag, "_rr"}, 64'({route_req_3_out, route_req_2_out, route_req_1_out, route_req_0_out}),
        64'(exp_rr));
    chk({tag, "_tail"}, 64'(tail_out), 64'(exp_tail));
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_thanks(input logic [3:0] t);
    {thanks_3_in, thanks_2_in, thanks_1_in, thanks_0_in} = t;
  endtask

  task automatic push(input logic [63:0] f);
    valid_in = 1'b1;
    data_in  = f;
    step();
    valid_in = 1'b0;
  endtask

  logic [63:0] flits [4];
  int yummy_cnt;

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; data_in = '0; set_thanks(4'b0000);
    step();
    chk_out("reset", 1'b0, 4'b0000, 1'b0);
    chk("reset_yummy", 64'(yummy_out), 64'd0);
    chk("reset_ovf", 64'(overflow_err), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single-flit packet to output 2
    push(hdr(8'd0, 2'd2, 16'hA001));
    chk_out("t1_head", 1'b1, 4'b0100, 1'b1);
    chk("t1_data", data_out, hdr(8'd0, 2'd2, 16'hA001));
    chk("t1_yummy_pre", 64'(yummy_out), 64'd0);
    set_thanks(4'b0100);
    step();
    set_thanks(4'b0000);
    chk("t1_yummy", 64'(yummy_out), 64'd1);
    chk_out("t1_empty", 1'b0, 4'b0000, 1'b0);
    step();
    chk("t1_yummy_off", 64'(yummy_out), 64'd0);

    // Four-flit packet to output 1: route held on body flits, tail only on the last
    flits[0] = hdr(8'd3, 2'd1, 16'hB000);
    flits[1] = body(16'hB001);
    flits[2] = body(16'hB002);
    flits[3] = body(16'hB003);
    for (int i = 0; i < 4; i++) push(flits[i]);
    yummy_cnt = 0;
    set_thanks(4'b0010);
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("t2_f%0d", i), 1'b1, 4'b0010, (i == 3));
      chk($sformatf("t2_data%0d", i), data_out, flits[i]);
      step();
      if (yummy_out) yummy_cnt++;
    end
    set_thanks(4'b0000);
    chk_out("t2_empty", 1'b0, 4'b0000, 1'b0);
    step();
    if (yummy_out) yummy_cnt++;
    chk("t2_yummy_count", 64'(yummy_cnt), 64'd4);

    // Thanks from the wrong output is ignored
    push(hdr(8'd0, 2'd0, 16'hC000));
    set_thanks(4'b1000);
    step();
    step();
    chk_out("t3_hold", 1'b1, 4'b0001, 1'b1);
    chk("t3_yummy", 64'(yummy_out), 64'd0);
    chk("t3_data", data_out, hdr(8'd0, 2'd0, 16'hC000));
    set_thanks(4'b0001);
    step();
    set_thanks(4'b0000);
    chk("t3_pop_yummy", 64'(yummy_out), 64'd1);
    chk_out("t3_empty", 1'b0, 4'b0000, 1'b0);
    step();

    // Full FIFO with simultaneous push and pop; pointers wrap here
    for (int i = 0; i < 4; i++) push(hdr(8'd0, 2'd2, 16'hD000 + 16'(i)));
    valid_in = 1'b1; data_in = hdr(8'd0, 2'd2, 16'hD004); set_thanks(4'b0100);
    step();
    valid_in = 1'b0;
    chk("t4_yummy", 64'(yummy_out), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t4_order%0d", i), data_out, hdr(8'd0, 2'd2, 16'hD000 + 16'(i)));
      chk($sformatf("t4_valid%0d", i), 64'(valid_out), 64'd1);
      step();
    end
    set_thanks(4'b0000);
    chk_out("t4_empty", 1'b0, 4'b0000, 1'b0);
    step();

    // Overflow: fifth push into a full FIFO without a pop is dropped
    for (int i = 0; i < 4; i++) push(hdr(8'd0, 2'd2, 16'hE000 + 16'(i)));
    chk("t5_ovf_pre", 64'(overflow_err), 64'd0);
    push(hdr(8'd0, 2'd2, 16'hE004));
    chk("t5_ovf", 64'(overflow_err), 64'(EXP_OVF));
    set_thanks(4'b0100);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_order%0d", i), data_out, hdr(8'd0, 2'd2, 16'hE000 + 16'(i)));
      step();
    end
    set_thanks(4'b0000);
    chk_out("t5_dropped", 1'b0, 4'b0000, 1'b0);
    chk("t5_ovf_sticky", 64'(overflow_err), 64'(EXP_OVF));

    // Reset in the middle of a len=5 packet
    push(hdr(8'd5, 2'd3, 16'hF000));
    push(body(16'hF001));
    push(body(16'hF002));
    set_thanks(4'b1000);
    step();
    step();
    set_thanks(4'b0000);
    chk_out("t6_mid", 1'b1, 4'b1000, 1'b0);
    chk("t6_mid_data", data_out, body(16'hF002));
    #2 rst_n = 1'b0;
    #1;
    chk_out("t6_reset", 1'b0, 4'b0000, 1'b0);
    chk("t6_reset_yummy", 64'(yummy_out), 64'd0);
    chk("t6_reset_ovf", 64'(overflow_err), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    push(hdr(8'd0, 2'd1, 16'hF100));
    chk_out("t6_after", 1'b1, 4'b0010, 1'b1);
    chk("t6_after_data", data_out, hdr(8'd0, 2'd1, 16'hF100));
    set_thanks(4'b0010);
    step();
    set_thanks(4'b0000);
    chk("t6_after_yummy", 64'(yummy_out), 64'd1);
    chk_out("t6_after_empty", 1'b0, 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_xbar_input_port.md
IO_XBAR_INPUT_PORT -- requirements
Module: io_xbar_input_port

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning input buffer entries; it equals the credit count of the upstream sender (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port valid_in  input  1  flit present on data_in this cycle.
REQ-005 SHALL have port data_in  input  `DATA_WIDTH  incoming flit.
REQ-006 SHALL have port yummy_out  output  1  credit return; one pulse per popped flit.
REQ-007 SHALL have ports thanks_0_in..thanks_3_in  input  1 each  output port N consumed the head flit.
REQ-008 SHALL have port valid_out  output  1  FIFO non-empty.
REQ-009 SHALL have port data_out  output  `DATA_WIDTH  FIFO head flit.
REQ-010 SHALL have ports route_req_0_out..route_req_3_out  output  1 each  one-hot request toward output port N.
REQ-011 SHALL have port tail_out  output  1  head flit is the last flit of its packet.
REQ-012 SHALL have port overflow_err  output  1  sticky overflow flag; see Configuration.

Function
REQ-013 SHALL push data_in into a FIFO_DEPTH-entry circular buffer when valid_in=1; the flit is visible on data_out/valid_out the cycle after the push.
REQ-014 SHALL pop the head when valid_out=1 and thanks_N_in=1 for the N whose route_req_N_out=1; thanks on any other port SHALL be ignored.
REQ-015 SHALL drive yummy_out from a register: high exactly one cycle after each pop, otherwise low.
REQ-016 SHALL accept a push to a full FIFO only if a pop occurs in the same cycle; otherwise the flit is dropped.
REQ-017 SHALL, on simultaneous push and pop, keep occupancy unchanged and wrap read/write pointers modulo FIFO_DEPTH.
REQ-018 SHALL run a two-state FSM: HEADER (head is a header flit) and BODY (head is a payload flit).
REQ-019 SHALL in HEADER decode length = data_out[`DATA_WIDTH-`CHIP_ID_WIDTH-2*`XY_WIDTH-4 -: `PAYLOAD_LEN] and route = data_out[`DATA_WIDTH-`CHIP_ID_WIDTH-`XY_WIDTH+1 : `DATA_WIDTH-`CHIP_ID_WIDTH-`XY_WIDTH] (X-coordinate low two bits).
REQ-020 SHALL on header pop with length>0: latch route, load remaining counter with length, go to BODY; with length=0: stay in HEADER.
REQ-021 SHALL on each BODY pop decrement the counter; on the pop with counter=1 return to HEADER.
REQ-022 SHALL assert route_req_N_out (N = decoded route in HEADER, latched route in BODY) only while valid_out=1; all four SHALL be low when empty.
REQ-023 SHALL assert tail_out when valid_out=1 and either (HEADER and length=0) or (BODY and counter=1).
REQ-024 SHALL hold route_req and tail stable while the head is not popped.

Reset
REQ-025 SHALL on rst_n=0 immediately empty the FIFO, set pointers/counter to 0, FSM to HEADER, clear overflow_err.
REQ-026 SHALL drive valid_out=0, yummy_out=0, tail_out=0, all route_req=0 during reset; data_out is don't-care.
REQ-027 SHALL discard a partially received packet on reset mid-packet; the upstream credit counter is reset by the same rst_n.

Configuration
REQ-028 SHALL, when IO_XBAR_INPUT_OVERFLOW_CHECK_EN is defined, set overflow_err to 1 on any dropped push (REQ-016) and hold it until reset.
REQ-029 SHALL, when IO_XBAR_INPUT_OVERFLOW_CHECK_EN is undefined, tie overflow_err to 0 and include no overflow-detection logic.

Verification
REQ-030 SHALL cover: header len=0, route=2 pushed -> next cycle valid_out=1, route_req_2_out=1, tail_out=1; thanks_2_in -> yummy_out=1 one cycle later, valid_out=0.
REQ-031 SHALL cover: header len=3 route=1 + 3 body flits, thanks_1_in each cycle -> route_req_1_out held 4 flits, tail_out only on 4th, exactly 4 yummy pulses.
REQ-032 SHALL cover: head requesting route 0, thanks_3_in=1 -> no pop, no yummy, outputs unchanged.
REQ-033 SHALL cover: 4 pushes with no thanks (depth 4), then push+pop same cycle -> occupancy stays 4, FIFO order preserved across pointer wrap.
REQ-034 SHALL cover: 5th push with full FIFO and no pop, macro defined -> flit dropped, overflow_err=1 until rst_n=0; macro undefined -> overflow_err=0.
REQ-035 SHALL cover: rst_n low after 2nd flit of len=5 packet -> valid_out=0 immediately; next header after reset decoded correctly in HEADER.
